// File: rtl/y_delta_update_engine_if.sv
// y_delta_update_engine_if: change-entry stream plus banked Y SRAM port bundle.
interface y_delta_update_engine_if #(
  parameter int DATA_W = 24,
  parameter int WORD_W = 256,
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 16
);
  logic              chg_valid;
  logic              chg_ready;
  logic [IDX_W-1:0]  chg_row;
  logic [IDX_W-1:0]  chg_col;
  logic [DATA_W-1:0] chg_real;
  logic [DATA_W-1:0] chg_img;
  logic [ADDR_W-1:0] sram_rd_addr1;
  logic [ADDR_W-1:0] sram_rd_addr2;
  logic [WORD_W-1:0] sram_rd_data1;
  logic [WORD_W-1:0] sram_rd_data2;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_wr_addr;
  logic [WORD_W-1:0] sram_wr_data;
  modport master (
    output chg_valid, chg_row, chg_col, chg_real, chg_img, sram_rd_data1, sram_rd_data2,
    input  chg_ready, sram_rd_addr1, sram_rd_addr2, sram_we, sram_wr_addr, sram_wr_data
  );
  modport slave (
    input  chg_valid, chg_row, chg_col, chg_real, chg_img, sram_rd_data1, sram_rd_data2,
    output chg_ready, sram_rd_addr1, sram_rd_addr2, sram_we, sram_wr_addr, sram_wr_data
  );
endinterface

// File: rtl/y_delta_update_engine.sv
// y_delta_update_engine: FIFO-fed read-modify-write stamping of branch deltas into the banked Y SRAM.
// Optional macro Y_SATURATE_EN: component add/sub saturates instead of wrapping.
module y_delta_update_engine #(
  parameter int DATA_W        = 24,
  parameter int SLOTS         = 4,
  parameter int WORD_W        = 256,
  parameter int WORDS_PER_ROW = 64,
  parameter int ADDR_W        = 11,
  parameter int IDX_W         = 16,
  parameter int N_NODES       = 256,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  y_delta_update_engine_if.slave bus,
  output logic                   o_busy,
  output logic                   o_upd_done,
  output logic                   o_err_idx,
  output logic [15:0]            o_upd_count
);
  localparam int P  = WORD_W / SLOTS;
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * IDX_W + 2 * DATA_W;
  localparam int RW = $clog2(WORDS_PER_ROW);
  localparam int CW = $clog2(SLOTS);
  localparam int WB = $clog2(WORD_W);
  typedef enum logic [2:0] {IDLE, RD_D, WR_D1, WR_D2, RD_O, WR_O1, WR_O2, FIN} state_t;
  state_t            r_st;
  logic [EW-1:0]     r_fifo [FIFO_DEPTH];
  logic [FA:0]       r_wp, r_rp;
  logic [IDX_W-1:0]  r_row, r_col;
  logic [DATA_W-1:0] r_dre, r_dim;
  logic [WORD_W-1:0] r_w2;
  logic [ADDR_W-1:0] r_rd1, r_rd2, r_wa;
  logic              r_we, r_done, r_err;
  logic [15:0]       r_cnt;
  logic              w_empty, w_full, w_pop, w_push, w_bad, w_sub;
  logic [IDX_W-1:0]  w_hr, w_hc;
  logic [DATA_W-1:0] w_hre, w_him;
  logic [WORD_W-1:0] w_src, w_wr;
  logic [31:0]       w_k;
  logic [WB-1:0]     w_lsb;
  logic [2*DATA_W-1:0] w_old;
  function automatic logic [ADDR_W-1:0] f_addr(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return ADDR_W'((32'(r) << RW) + (32'(c) >> CW));
  endfunction
  function automatic logic [DATA_W-1:0] f_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic sub);
    logic [DATA_W:0] s;
    s = sub ? {a[DATA_W-1], a} - {b[DATA_W-1], b} : {a[DATA_W-1], a} + {b[DATA_W-1], b};
`ifdef Y_SATURATE_EN
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return s[DATA_W-1:0];
  endfunction
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[FA] != r_rp[FA]) && (r_wp[FA-1:0] == r_rp[FA-1:0]);
  assign w_pop   = (r_st == IDLE) && !w_empty;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign bus.chg_ready = i_reset && (!w_full || w_pop);
  assign w_push  = bus.chg_valid && bus.chg_ready;
  assign {w_hr, w_hc, w_hre, w_him} = r_fifo[r_rp[FA-1:0]];
  assign w_bad   = (32'(w_hr) >= N_NODES) || (32'(w_hc) >= N_NODES);
  always_ff @(posedge i_clock)
    if (w_push) r_fifo[r_wp[FA-1:0]] <= {bus.chg_row, bus.chg_col, bus.chg_real, bus.chg_img};
  // Port 1 carries (r,r) then (r,c); port 2 carries (c,c) then (c,r), so slot follows that order
  always_comb begin
    w_sub = (r_st == WR_O1) || (r_st == WR_O2);
    w_src = (r_st == WR_D1 || r_st == WR_O1) ? bus.sram_rd_data1 : r_w2;
    w_k   = (r_st == WR_D1 || r_st == WR_O2) ? 32'(r_row) % SLOTS : 32'(r_col) % SLOTS;
    w_lsb = WB'(w_k * P);
    w_old = w_src[w_lsb +: 2*DATA_W];
    w_wr  = w_src;
    w_wr[w_lsb +: 2*DATA_W] = {f_op(w_old[2*DATA_W-1:DATA_W], r_dre, w_sub), f_op(w_old[DATA_W-1:0], r_dim, w_sub)};
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      r_st <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_row <= '0;
      r_col <= '0;
      r_dre <= '0;
      r_dim <= '0;
      r_w2 <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_wa <= '0;
      r_we <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_we <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case (r_st)
        IDLE: if (w_pop) begin
          r_row <= w_hr;
          r_col <= w_hc;
          r_dre <= w_hre;
          r_dim <= w_him;
          if (w_bad) begin
            r_err <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_st <= RD_D;
            r_rd1 <= f_addr(w_hr, w_hr);
            r_rd2 <= f_addr(w_hc, w_hc);
          end
        end
        RD_D: begin
          r_st <= WR_D1;
          r_we <= 1'b1;
          r_wa <= r_rd1;
        end
        WR_D1: begin
          r_w2 <= bus.sram_rd_data2;
          if (r_row == r_col) begin
            r_st <= FIN;
            r_done <= 1'b1;
            r_cnt <= r_cnt + 16'd1;
          end else begin
            r_st <= WR_D2;
            r_we <= 1'b1;
            r_wa <= r_rd2;
          end
        end
        WR_D2: begin
          r_st <= RD_O;
          r_rd1 <= f_addr(r_row, r_col);
          r_rd2 <= f_addr(r_col, r_row);
        end
        RD_O: begin
          r_st <= WR_O1;
          r_we <= 1'b1;
          r_wa <= r_rd1;
        end
        WR_O1: begin
          r_w2 <= bus.sram_rd_data2;
          r_st <= WR_O2;
          r_we <= 1'b1;
          r_wa <= r_rd2;
        end
        WR_O2: begin
          r_st <= FIN;
          r_done <= 1'b1;
          r_cnt <= r_cnt + 16'd1;
        end
        default: r_st <= IDLE;
      endcase
    end
  assign bus.sram_rd_addr1 = r_rd1;
  assign bus.sram_rd_addr2 = r_rd2;
  assign bus.sram_we       = r_we;
  assign bus.sram_wr_addr  = r_wa;
  assign bus.sram_wr_data  = w_wr;
  assign o_busy      = !w_empty || (r_st != IDLE);
  assign o_upd_done  = r_done;
  assign o_err_idx   = r_err;
  assign o_upd_count = r_cnt;
endmodule

// File: tb/tb_y_delta_update_engine.sv
// tb_y_delta_update_engine: directed checks of stamping, shunts, index errors, FIFO backpressure, overflow and reset.
module tb_y_delta_update_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err;
  logic [15:0] cnt;
  logic [255:0] mem [2048];
  logic clr = 1'b0, pre_en = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [255:0] pre_data = '0;
  int nwr = 0;
  int checks = 0, errors = 0;
  y_delta_update_engine_if #(.DATA_W(24), .WORD_W(256), .ADDR_W(11), .IDX_W(16)) bus();
  y_delta_update_engine dut (
    .i_clock(clk), .i_reset(rst_n), .bus(bus),
    .o_busy(busy), .o_upd_done(done), .o_err_idx(err), .o_upd_count(cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end else if (bus.sram_we) mem[bus.sram_wr_addr] <= bus.sram_wr_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
    bus.sram_rd_data1 <= mem[bus.sram_rd_addr1];
    bus.sram_rd_data2 <= mem[bus.sram_rd_addr2];
    if (bus.sram_we) nwr++;
  end
  function automatic logic [47:0] slot_of(input int a, input int k);
    return mem[a][k*64 +: 48];
  endfunction
  task automatic preset(input logic [10:0] a, input logic [255:0] w);
    @(negedge clk);
    pre_addr = a;
    pre_data = w;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask
  task automatic push(input logic [15:0] r, input logic [15:0] c, input logic [23:0] re, input logic [23:0] im, inout int stalls);
    int n;
    @(negedge clk);
    bus.chg_valid = 1'b1;
    bus.chg_row = r;
    bus.chg_col = c;
    bus.chg_real = re;
    bus.chg_img = im;
    n = 0;
    while (!bus.chg_ready && n < 100) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL push_timeout ready stuck low for entry r=%0d c=%0d", r, c);
    end
    @(posedge clk);
    #1 bus.chg_valid = 1'b0;
  endtask
  task automatic wait_done(output int k, output logic e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
    e = err;
  endtask
  task automatic test_reset;
    checks++;
    if ({busy, done, err, cnt, bus.sram_we, bus.chg_ready} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b cnt=%0d we=%b rdy=%b want all 0", busy, done, err, cnt, bus.sram_we, bus.chg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.chg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", bus.chg_ready, busy);
    end
  endtask
  task automatic test_stamp;
    logic [255:0] w;
    int k, w0, s;
    logic e;
    w = '0;
    w[0 +: 48] = 48'h123456_abcdef;
    w[176 +: 16] = 16'hBEEF;
    preset(11'd128, w);
    w0 = nwr;
    s = 0;
    push(16'd2, 16'd5, 24'd1, 24'd1, s);
    wait_done(k, e);
    checks++;
    if (k != 8 || e !== 1'b0) begin
      errors++;
      $display("FAIL stamp_latency got %0d cycles err=%b want 8 err=0", k, e);
    end
    @(negedge clk);
    checks++;
    if (nwr - w0 != 4) begin
      errors++;
      $display("FAIL stamp_writes got %0d want 4", nwr - w0);
    end
    checks++;
    if (slot_of(128, 2) !== 48'h000001_000001 || slot_of(321, 1) !== 48'h000001_000001) begin
      errors++;
      $display("FAIL stamp_diag got Y22=%h Y55=%h want 000001000001", slot_of(128, 2), slot_of(321, 1));
    end
    checks++;
    if (slot_of(129, 1) !== 48'hFFFFFF_FFFFFF || slot_of(320, 2) !== 48'hFFFFFF_FFFFFF) begin
      errors++;
      $display("FAIL stamp_offdiag got Y25=%h Y52=%h want ffffffffffff", slot_of(129, 1), slot_of(320, 2));
    end
    checks++;
    if (mem[128][0 +: 48] !== 48'h123456_abcdef || mem[128][176 +: 16] !== 16'hBEEF) begin
      errors++;
      $display("FAIL stamp_preserve got slot0=%h pad=%h want 123456abcdef beef", mem[128][0 +: 48], mem[128][176 +: 16]);
    end
    checks++;
    if (cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stamp_count got cnt=%0d busy=%b want 1 0", cnt, busy);
    end
  endtask
  task automatic test_shunt;
    int k, w0, s;
    logic e;
    w0 = nwr;
    s = 0;
    push(16'd7, 16'd7, 24'h000010, 24'd0, s);
    wait_done(k, e);
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL shunt_latency got %0d want 4", k);
    end
    @(negedge clk);
    checks++;
    if (nwr - w0 != 1 || slot_of(449, 3) !== 48'h000010_000000) begin
      errors++;
      $display("FAIL shunt_write got writes=%0d Y77=%h want 1 000010000000", nwr - w0, slot_of(449, 3));
    end
    checks++;
    if (cnt !== 16'd2) begin
      errors++;
      $display("FAIL shunt_count got %0d want 2", cnt);
    end
  endtask
  task automatic test_err_idx;
    int k, w0, s;
    logic e;
    w0 = nwr;
    s = 0;
    push(16'd300, 16'd1, 24'd1, 24'd1, s);
    wait_done(k, e);
    checks++;
    if (k != 2 || e !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse got cycles=%0d err=%b want 2 1", k, e);
    end
    @(negedge clk);
    checks++;
    if (nwr != w0 || cnt !== 16'd2 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL err_effect got writes=%0d cnt=%0d err=%b done=%b want 0 2 0 0", nwr - w0, cnt, err, done);
    end
    push(16'd1, 16'd1, 24'd5, 24'd0, s);
    wait_done(k, e);
    @(negedge clk);
    checks++;
    if (slot_of(64, 1) !== 48'h000005_000000 || cnt !== 16'd3) begin
      errors++;
      $display("FAIL err_next got Y11=%h cnt=%0d want 000005000000 3", slot_of(64, 1), cnt);
    end
  endtask
  task automatic test_overflow;
    logic [255:0] w;
    logic [23:0] exp_re;
    int k, s;
    logic e;
    w = mem[128];
    w[128 +: 48] = 48'h7FFFFF_000000;
    preset(11'd128, w);
    s = 0;
    push(16'd2, 16'd2, 24'd1, 24'd0, s);
    wait_done(k, e);
    @(negedge clk);
`ifdef Y_SATURATE_EN
    exp_re = 24'h7FFFFF;
`else
    exp_re = 24'h800000;
`endif
    checks++;
    if (slot_of(128, 2) !== {exp_re, 24'h000000}) begin
      errors++;
      $display("FAIL overflow got Y22=%h want %h000000", slot_of(128, 2), exp_re);
    end
  endtask
  task automatic test_back_to_back;
    int s, n;
    s = 0;
    for (int i = 0; i < 11; i++) push(16'd4, 16'd6, 24'd1, 24'd0, s);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL b2b_drain busy still %b after %0d cycles want 0", busy, n);
    end
    @(negedge clk);
    checks++;
    if (s == 0) begin
      errors++;
      $display("FAIL b2b_backpressure got %0d stall cycles want >0", s);
    end
    checks++;
    if (cnt !== 16'd15) begin
      errors++;
      $display("FAIL b2b_count got %0d want 15", cnt);
    end
    checks++;
    if (slot_of(257, 0) !== 48'h00000B_000000 || slot_of(385, 2) !== 48'h00000B_000000) begin
      errors++;
      $display("FAIL b2b_diag got Y44=%h Y66=%h want 00000b000000", slot_of(257, 0), slot_of(385, 2));
    end
    checks++;
    if (slot_of(257, 2) !== 48'hFFFFF5_000000 || slot_of(385, 0) !== 48'hFFFFF5_000000) begin
      errors++;
      $display("FAIL b2b_offdiag got Y46=%h Y64=%h want fffff5000000", slot_of(257, 2), slot_of(385, 0));
    end
  endtask
  task automatic test_reset_mid;
    int s, w0;
    s = 0;
    push(16'd8, 16'd9, 24'd1, 24'd0, s);
    push(16'd10, 16'd10, 24'd1, 24'd0, s);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.sram_we !== 1'b1 || bus.sram_wr_addr !== 11'd578) begin
      errors++;
      $display("FAIL mid_state got we=%b addr=%0d want 1 578", bus.sram_we, bus.sram_wr_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, cnt, bus.sram_we, bus.chg_ready} !== 21'd0) begin
      errors++;
      $display("FAIL mid_async got busy=%b done=%b err=%b cnt=%0d we=%b rdy=%b want all 0", busy, done, err, cnt, bus.sram_we, bus.chg_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = nwr;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || nwr != w0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_after got busy=%b writes=%0d cnt=%0d want 0 0 0", busy, nwr - w0, cnt);
    end
    checks++;
    if (slot_of(514, 0) !== 48'h000001_000000 || slot_of(578, 1) !== 48'h0 || slot_of(642, 2) !== 48'h0) begin
      errors++;
      $display("FAIL mid_partial got Y88=%h Y99=%h Y1010=%h want 000001000000 0 0", slot_of(514, 0), slot_of(578, 1), slot_of(642, 2));
    end
  endtask
  initial begin
    bus.chg_valid = 1'b0;
    bus.chg_row = '0;
    bus.chg_col = '0;
    bus.chg_real = '0;
    bus.chg_img = '0;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    test_reset;
    test_stamp;
    test_shunt;
    test_err_idx;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
